// File: rtl/phasecalc_pkg.sv
// Purpose : shared types, widths and constants for the CORDIC phase calculator.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Holds the FSM state type, the fixed-point formats, the 90/180-degree constants
// and the atan(2^-i) table in degrees with FRACBITS+4 fractional bits.
package phasecalc_pkg;

    // External formats.
    localparam int INPUTBITSIZE  = 13;
    localparam int OUTPUTBITSIZE = 19;
    localparam int FRACBITS      = 10;
    localparam int NITER         = 16;
    localparam int IDX_W         = $clog2(NITER);

    // x/y datapath: INPUTBITSIZE+3 integer bits (gain growth, negation headroom,
    // guard) extended by XY_FRAC low bits that the normaliser fills. Vectors are
    // left-shifted so the larger component's leading one sits at NORM_MSB, which
    // keeps the truncation error of the shifts far below the angle resolution
    // even for tiny inputs such as (1, 1).
    localparam int XY_FRAC  = 6;
    localparam int XY_W     = INPUTBITSIZE + 3 + XY_FRAC;
    localparam int NORM_MSB = INPUTBITSIZE - 1 + XY_FRAC;
    localparam int MAG_W    = INPUTBITSIZE + 1;     // |value| before normalising
    localparam int SHIFT_W  = 5;                    // holds 0..NORM_MSB

    // z accumulator: degrees with FRACBITS+Z_EXTRA fractional bits.
    localparam int Z_EXTRA = 4;
    localparam int Z_FRAC  = FRACBITS + Z_EXTRA;
    localparam int Z_W     = 24;

    localparam logic signed [Z_W-1:0] Z_DEG90     = 24'sd1474560;   // 90  << 14
    localparam logic signed [Z_W-1:0] Z_DEG180    = 24'sd2949120;   // 180 << 14
    localparam logic signed [Z_W-1:0] Z_HALF_LSB  = 24'sd8;         // 0.5 output LSB
    localparam logic signed [Z_W-1:0] Z_ANGLE_MAX = 24'sd184320;    // 180 in Q8.10
    localparam logic signed [Z_W-1:0] Z_ANGLE_MIN = -24'sd184320;

    localparam logic signed [OUTPUTBITSIZE-1:0] ANGLE_POS180 = 19'sd184320;
    localparam logic signed [OUTPUTBITSIZE-1:0] ANGLE_NEG180 = -19'sd184320;

    // round(atan(2^-i) * 180/pi * 2^14), i = 0..15
    localparam logic signed [Z_W-1:0] ATAN_ROM [NITER] = '{
        24'sd737280, 24'sd435242, 24'sd229970, 24'sd116736,
        24'sd58595,  24'sd29326,  24'sd14667,  24'sd7334,
        24'sd3667,   24'sd1833,   24'sd917,    24'sd458,
        24'sd229,    24'sd115,    24'sd57,     24'sd29
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [XY_W-1:0] abs_xy(input logic signed [XY_W-1:0] v);
        return v[XY_W-1] ? -v : v;
    endfunction

endpackage

// File: rtl/phasecalc_atan_rom.sv
// Purpose : atan(2^-idx) lookup in degrees (Q.14), one entry per CORDIC step.
// Latency : combinational.
// Backpressure: none.
//
// Ports: idx (iteration index in), atan_dat (signed angle increment out).
module phasecalc_atan_rom
    import phasecalc_pkg::*;
(
    input  logic        [IDX_W-1:0] idx,
    output logic signed [Z_W-1:0]   atan_dat
);

    assign atan_dat = ATAN_ROM[idx];

endmodule

// File: rtl/phasecalc.sv
// Purpose : sequential CORDIC (vectoring) phase calculator, angle = atan2(y, x) in Q8.10 degrees.
// Latency : NITER+2 clocks from the accepted start edge to busy=1 (18 by default).
// Backpressure: none; start is ignored while a computation is in flight.
//
// Ports: clock, reset (sync, active-high), start (1-cycle pulse, samples x/y),
//        x/y (signed INPUTBITSIZE), busy (1 = angle valid, 0 while computing),
//        angle (signed OUTPUTBITSIZE, range [-180, +180] degrees).
// Build option: PHASECALC_ROUND_EN selects round-to-nearest on the final
//        z -> angle conversion; otherwise the extra fraction bits are floored.
module phasecalc
    import phasecalc_pkg::*;
(
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    output logic                            busy,
    input  logic signed [INPUTBITSIZE-1:0]  x,
    input  logic signed [INPUTBITSIZE-1:0]  y,
    output logic signed [OUTPUTBITSIZE-1:0] angle
);

    state_t                     state_q, state_d;
    logic signed [XY_W-1:0]     x_q, x_d;
    logic signed [XY_W-1:0]     y_q, y_d;
    logic signed [Z_W-1:0]      z_q, z_d;
    logic        [IDX_W-1:0]    i_q, i_d;
    logic                       fixed_q, fixed_d;   // result already exact, skip micro-rotations
    logic                       busy_q, busy_d;
    logic signed [OUTPUTBITSIZE-1:0] angle_q, angle_d;

    logic signed [Z_W-1:0]      atan_dat;

    // Pre-rotation / normalisation datapath (used in PRE).
    logic signed [XY_W-1:0]     pre_x, pre_y;
    logic signed [Z_W-1:0]      pre_z;
    logic        [MAG_W-1:0]    pre_mag;
    logic        [SHIFT_W-1:0]  msb_pos, norm_sh;
    logic signed [XY_W-1:0]     norm_x, norm_y;

    // Micro-rotation datapath (used in ITER).
    logic signed [XY_W-1:0]     x_sh, y_sh;

    // Output conversion (used in DONE).
    logic signed [Z_W-1:0]      z_fin, z_out;
    logic signed [OUTPUTBITSIZE-1:0] angle_sat;

    phasecalc_atan_rom u_atan_rom (
        .idx      (i_q),
        .atan_dat (atan_dat)
    );

    always_comb begin
        // Fold the left half-plane onto the right so the CORDIC only has to
        // cover [-90, +90], well inside its +/-99.9 degree convergence range.
        pre_x = x_q;
        pre_y = y_q;
        pre_z = '0;
        if (x_q[XY_W-1]) begin
            if (!y_q[XY_W-1]) begin
                pre_x = y_q;
                pre_y = -x_q;
                pre_z = Z_DEG90;
            end else begin
                pre_x = -y_q;
                pre_y = x_q;
                pre_z = -Z_DEG90;
            end
        end

        // OR of magnitudes has the same leading-one position as the larger one.
        pre_mag = MAG_W'(abs_xy(pre_x) | abs_xy(pre_y));
        msb_pos = '0;
        for (int k = 0; k < MAG_W; k++) begin
            if (pre_mag[k]) begin
                msb_pos = SHIFT_W'(k);
            end
        end
        norm_sh = SHIFT_W'(NORM_MSB) - msb_pos;
        norm_x  = pre_x <<< norm_sh;
        norm_y  = pre_y <<< norm_sh;

        x_sh = x_q >>> i_q;
        y_sh = y_q >>> i_q;

`ifdef PHASECALC_ROUND_EN
        z_fin = z_q + Z_HALF_LSB;
`else
        z_fin = z_q;
`endif
        z_out = z_fin >>> Z_EXTRA;
        if (z_out > Z_ANGLE_MAX) begin
            angle_sat = ANGLE_POS180;
        end else if (z_out < Z_ANGLE_MIN) begin
            angle_sat = ANGLE_NEG180;
        end else begin
            angle_sat = z_out[OUTPUTBITSIZE-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        i_d     = i_q;
        fixed_d = fixed_q;
        busy_d  = busy_q;
        angle_d = angle_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = XY_W'(x);
                    y_d     = XY_W'(y);
                    z_d     = '0;
                    i_d     = '0;
                    fixed_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = PRE;
                end
            end

            PRE: begin
                i_d     = '0;
                state_d = ITER;
                if (y_q == '0) begin
                    // On the real axis the answer is exact: 0 for x >= 0
                    // (including the origin) and always +180 for x < 0.
                    fixed_d = 1'b1;
                    z_d     = x_q[XY_W-1] ? Z_DEG180 : '0;
                end else begin
                    x_d = norm_x;
                    y_d = norm_y;
                    z_d = pre_z;
                end
            end

            ITER: begin
                if (!fixed_q) begin
                    if (!y_q[XY_W-1]) begin
                        x_d = x_q + y_sh;
                        y_d = y_q - x_sh;
                        z_d = z_q + atan_dat;
                    end else begin
                        x_d = x_q - y_sh;
                        y_d = y_q + x_sh;
                        z_d = z_q - atan_dat;
                    end
                end
                i_d = i_q + IDX_W'(1);
                if (i_q == IDX_W'(NITER - 1)) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                angle_d = angle_sat;
                busy_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            i_q     <= '0;
            fixed_q <= 1'b0;
            busy_q  <= 1'b0;
            angle_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            i_q     <= i_d;
            fixed_q <= fixed_d;
            busy_q  <= busy_d;
            angle_q <= angle_d;
        end
    end

    assign busy  = busy_q;
    assign angle = angle_q;

endmodule

// File: tb/tb_phasecalc.sv
// Purpose : self-checking bench for phasecalc against a real-valued atan2 model.
// Latency : expects busy=1 exactly 18 clocks after each accepted start.
// Backpressure: n/a.
module tb_phasecalc;

    localparam int IW  = 13;
    localparam int OW  = 19;
    localparam int LAT = 18;
    localparam int TOL = 51;    // 0.05 degree in 1/1024-degree LSBs

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 start;
    logic                 busy;
    logic signed [IW-1:0] x;
    logic signed [IW-1:0] y;
    logic signed [OW-1:0] angle;

    int total = 0;
    int bad   = 0;

    phasecalc dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .x     (x),
        .y     (y),
        .angle (angle)
    );

    always #5 clock = ~clock;

    // atan2 in degrees, Q8.10, nearest. The negative real axis is +180 by definition.
    function automatic int model_angle(input int xi, input int yi);
        real deg;
        if (xi == 0 && yi == 0) return 0;
        if (yi == 0 && xi < 0) return 184320;
        deg = $atan2(real'(yi), real'(xi)) * 180.0 / 3.14159265358979323846;
        return int'($floor(deg * 1024.0 + 0.5));
    endfunction

    task automatic check_eq(input string tag, input logic signed [31:0] obs,
                            input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_tol(input string tag, input logic signed [31:0] obs,
                             input logic signed [31:0] exp);
        logic ok;
        ok = ((obs - exp) <= TOL) && ((exp - obs) <= TOL);
        total++;
        assert (ok === 1'b1) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d (+/-%0d)", tag, obs, exp, TOL);
        end
    endtask

    // Pulse start with (xi, yi), optionally re-pulse start with junk operands
    // after glitch_n clocks, and wait (bounded) for busy to rise.
    task automatic run_calc(input int xi, input int yi, input int glitch_n,
                            output logic busy_at_start, output int lat,
                            output logic signed [31:0] ang);
        int xv;
        int yv;
        xv = xi;
        yv = yi;
        @(negedge clock);
        x     = xv[IW-1:0];
        y     = yv[IW-1:0];
        start = 1'b1;
        @(posedge clock);
        #1;
        start         = 1'b0;
        busy_at_start = busy;
        lat           = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clock);
            #1;
            if (busy === 1'b1) begin
                lat = n;
                break;
            end
            if (n == glitch_n) begin
                x     = 13'sd3000;
                y     = -13'sd2500;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        ang   = angle;
    endtask

    initial begin
        int dx [12];
        int dy [12];
        logic bs;
        int lat;
        logic signed [31:0] ang;
        int rx;
        int ry;

        dx = '{1000,    0, 1000, -1000, -1000, -4096, 0,     0, 1, -4096,  4095, -1};
        dy = '{   0, 1000, 1000,     0, -1000,    -1, 0, -1000, 1,  4095, -4096,  0};

        reset = 1'b1;
        start = 1'b0;
        x     = '0;
        y     = '0;
        repeat (3) @(posedge clock);
        #1;
        check_eq("reset_busy", busy, 0);
        check_eq("reset_angle", angle, 0);
        reset = 1'b0;

        // Directed points, issued back to back: busy must fall on every accepted start.
        for (int k = 0; k < 12; k++) begin
            run_calc(dx[k], dy[k], 0, bs, lat, ang);
            if (k > 0) check_eq($sformatf("busy_drop[%0d]", k), bs, 0);
            check_eq($sformatf("latency[%0d]", k), lat, LAT);
            check_tol($sformatf("angle(%0d,%0d)", dx[k], dy[k]), ang, model_angle(dx[k], dy[k]));
        end

        // Exact boundary results.
        run_calc(-1000, 0, 0, bs, lat, ang);
        check_eq("neg_real_axis_180", ang, 184320);
        run_calc(0, 0, 0, bs, lat, ang);
        check_eq("origin_zero", ang, 0);
        run_calc(-4096, 0, 0, bs, lat, ang);
        check_eq("full_neg_axis_180", ang, 184320);

        // start during ITER is ignored: same latency, result of the original operands.
        run_calc(700, -300, 6, bs, lat, ang);
        check_eq("glitch_latency", lat, LAT);
        check_tol("glitch_angle", ang, model_angle(700, -300));

        // Reset in the middle of iteration 5 aborts the computation.
        run_calc(-2000, 1500, 0, bs, lat, ang);
        @(negedge clock);
        x     = 13'sd1234;
        y     = 13'sd567;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_angle", angle, 0);
        reset = 1'b0;
        repeat (25) @(posedge clock);
        #1;
        check_eq("abort_no_flag", busy, 0);
        run_calc(1234, 567, 0, bs, lat, ang);
        check_eq("post_abort_latency", lat, LAT);
        check_tol("post_abort_angle", ang, model_angle(1234, 567));

        // Random sweep: full-range and small-magnitude operands.
        for (int k = 0; k < 2000; k++) begin
            if (k % 4 == 3) begin
                rx = int'($urandom_range(0, 14)) - 7;
                ry = int'($urandom_range(0, 14)) - 7;
            end else begin
                rx = int'($urandom_range(0, 8191)) - 4096;
                ry = int'($urandom_range(0, 8191)) - 4096;
            end
            run_calc(rx, ry, 0, bs, lat, ang);
            check_eq($sformatf("rand_latency[%0d]", k), lat, LAT);
            check_tol($sformatf("rand_angle(%0d,%0d)", rx, ry), ang, model_angle(rx, ry));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
